// File: rtl/beat_interval_meter.sv
// Measures the time between successive beat pulses in prescaled ticks, with a
// refractory window after each accepted beat and a no-signal timeout.
module beat_interval_meter #(
    parameter int TICK_DIV = 1000,
    parameter int REFRACT  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       beat_in,
    input  logic       ready,
    output logic [7:0] interval,
    output logic       valid,
    output logic       overrun,
    output logic       no_signal
);

    localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);
    localparam logic [7:0]  REFRACT_CNT = 8'(REFRACT);

    typedef enum logic [1:0] {
        ST_WAIT_FIRST,
        ST_REFRACT,
        ST_ARMED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        sync1;
    logic        sync2;
    logic        sync_prev;
    logic        beat_edge;
    logic [15:0] prescaler;
    logic [7:0]  tick_count;
    logic [7:0]  tick_count_inc;
    logic        tick;
    logic        accept;
    logic        publish;
    logic        timeout;
    logic        clear_no_signal;
    logic [7:0]  publish_value;

    assign beat_edge      = sync2 & ~sync_prev;
    assign tick           = (prescaler == TICK_LAST);
    assign tick_count_inc = (tick_count == 8'hFF) ? 8'hFF : tick_count + 8'd1;
    // A tick landing in the same cycle as the beat still belongs to this interval.
    assign publish_value  = tick ? tick_count_inc : tick_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= beat_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_FIRST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        accept          = 1'b0;
        publish         = 1'b0;
        timeout         = 1'b0;
        clear_no_signal = 1'b0;
        if (!ena) begin
            state_next = ST_WAIT_FIRST;
        end else begin
            case (state)
                ST_WAIT_FIRST: begin
                    if (beat_edge) begin
                        accept          = 1'b1;
                        clear_no_signal = 1'b1;
                        state_next      = ST_REFRACT;
                    end
                end
                ST_REFRACT: begin
                    if (tick_count >= REFRACT_CNT) begin
                        state_next = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // A beat arriving together with the timeout takes priority.
                    if (beat_edge) begin
                        accept     = 1'b1;
                        publish    = 1'b1;
                        state_next = ST_REFRACT;
                    end else if (tick_count == 8'hFF) begin
                        timeout    = 1'b1;
                        state_next = ST_WAIT_FIRST;
                    end
                end
                default: begin
                    state_next = ST_WAIT_FIRST;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= 16'd0;
            tick_count <= 8'd0;
        end else if (!ena || accept) begin
            prescaler  <= 16'd0;
            tick_count <= 8'd0;
        end else begin
            prescaler <= tick ? 16'd0 : prescaler + 16'd1;
            if (tick) begin
                tick_count <= tick_count_inc;
            end
        end
    end

    // Result handshake keeps running even while the block is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval  <= 8'd0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            no_signal <= 1'b0;
        end else begin
            if (publish) begin
                interval <= publish_value;
                valid    <= 1'b1;
                if (valid && !ready) begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (timeout) begin
                no_signal <= 1'b1;
            end else if (clear_no_signal) begin
                no_signal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beat_interval_meter.sv
// Directed bench for beat_interval_meter with TICK_DIV=4, REFRACT=2; each beat
// interval below is hand-computed as floor(cycles_between_beats / 4).
module tb_beat_interval_meter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       beat_in;
    logic       ready;
    logic [7:0] interval;
    logic       valid;
    logic       overrun;
    logic       no_signal;

    int tests_run;
    int fail_count;

    beat_interval_meter #(
        .TICK_DIV(4),
        .REFRACT (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .beat_in  (beat_in),
        .ready    (ready),
        .interval (interval),
        .valid    (valid),
        .overrun  (overrun),
        .no_signal(no_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Every wait ends just after a rising edge, so inputs and samples stay clear of it.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        beat_in = 1'b0;
        rst_n   = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
    endtask

    // Pulse beat_in for two cycles, check the result slot three cycles after the
    // rise (the publish latency), then idle until gap cycles have elapsed.
    task automatic sendBeat(input int gap, input string tag, input logic exp_publish,
                            input int exp_interval);
        beat_in = 1'b1;
        waitCycles(2);
        beat_in = 1'b0;
        waitCycles(1);
        checkOutput({tag, "_valid"}, int'(valid), int'(exp_publish));
        if (exp_publish) begin
            checkOutput({tag, "_interval"}, int'(interval), exp_interval);
        end
        if (gap > 3) begin
            waitCycles(gap - 3);
        end
    endtask

    initial begin
        tests_run  = 0;
        fail_count = 0;
        ena        = 1'b1;
        ready      = 1'b1;
        beat_in    = 1'b0;
        rst_n      = 1'b0;
        #2;
        checkOutput("reset_interval", int'(interval), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        checkOutput("reset_no_signal", int'(no_signal), 0);
        applyReset();

        // Regular beats at 40, 41 and 39 cycles, consumer always ready.
        sendBeat(40, "s1_first", 1'b0, 0);
        sendBeat(4, "s1_b40", 1'b1, 10);
        checkOutput("s1_valid_one_cycle", int'(valid), 0);
        waitCycles(37);
        sendBeat(39, "s1_b41", 1'b1, 10);
        sendBeat(40, "s1_b39", 1'b1, 9);

        // A beat inside the refractory window is ignored.
        applyReset();
        sendBeat(6, "s2_first", 1'b0, 0);
        sendBeat(34, "s2_refract", 1'b0, 0);
        sendBeat(40, "s2_third", 1'b1, 10);

        // Consumer stalled: second result overwrites the first and flags overrun.
        applyReset();
        ready = 1'b0;
        sendBeat(40, "s3_first", 1'b0, 0);
        sendBeat(40, "s3_second", 1'b1, 10);
        checkOutput("s3_no_overrun_yet", int'(overrun), 0);
        sendBeat(4, "s3_third", 1'b1, 10);
        checkOutput("s3_overrun", int'(overrun), 1);
        ready = 1'b1;
        waitCycles(1);
        ready = 1'b0;
        checkOutput("s3_consumed_valid", int'(valid), 0);
        checkOutput("s3_overrun_sticky", int'(overrun), 1);
        checkOutput("s3_interval_held", int'(interval), 10);

        // Silence after one beat: counter saturates at tick 255 -> timeout.
        applyReset();
        ready = 1'b1;
        sendBeat(4, "s4_first", 1'b0, 0);
        waitCycles(1019);
        checkOutput("s4_before_timeout", int'(no_signal), 0);
        waitCycles(1);
        checkOutput("s4_timeout", int'(no_signal), 1);
        waitCycles(10);
        sendBeat(40, "s4_restart", 1'b0, 0);
        checkOutput("s4_no_signal_cleared", int'(no_signal), 0);
        sendBeat(4, "s4_next", 1'b1, 10);

        // Asynchronous reset mid-ARMED with a pending result.
        applyReset();
        ready = 1'b0;
        sendBeat(40, "s5_first", 1'b0, 0);
        sendBeat(20, "s5_second", 1'b1, 10);
        beat_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_async_interval", int'(interval), 0);
        checkOutput("s5_async_valid", int'(valid), 0);
        checkOutput("s5_async_overrun", int'(overrun), 0);
        checkOutput("s5_async_no_signal", int'(no_signal), 0);
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(2);
        beat_in = 1'b0;
        waitCycles(1);
        checkOutput("s5_release_no_publish", int'(valid), 0);
        waitCycles(37);
        sendBeat(4, "s5_after_release", 1'b1, 10);

        // Disabling between beats abandons the measurement.
        applyReset();
        ready = 1'b1;
        sendBeat(10, "s6_first", 1'b0, 0);
        ena = 1'b0;
        sendBeat(10, "s6_disabled", 1'b0, 0);
        ena = 1'b1;
        waitCycles(20);
        sendBeat(20, "s6_restart", 1'b0, 0);
        sendBeat(4, "s6_b20", 1'b1, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
